// File: rtl/sort_pkg.sv
// Shared types and the compare-swap decision for the streaming sorter.
// Exports sort_dir_e and cmp_swap(a, b, descend, signed_mode).
package sort_pkg;

  typedef enum logic {
    SORT_ASC  = 1'b0,
    SORT_DESC = 1'b1
  } sort_dir_e;

  localparam int unsigned KEY_MAX_W = 64;

  // Keys arrive widened to KEY_MAX_W bits (sign- or zero-extended by
  // the caller), so one function covers every key width.
  // Equal keys never swap, which keeps the network stable.
  function automatic logic cmp_swap(
    input logic [KEY_MAX_W-1:0] a,
    input logic [KEY_MAX_W-1:0] b,
    input logic                 descend,
    input logic                 signed_mode
  );
    logic gt;
    logic lt;
    if (signed_mode) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return (sort_dir_e'(descend) == SORT_DESC) ? lt : gt;
  endfunction

endpackage

// File: rtl/sort_cas_stage.sv
// One odd-even transposition layer: compare-swap, then register with tags.
// Ports: up_* from previous stage, advance from top, registered outputs.
module sort_cas_stage
  import sort_pkg::*;
#(
  parameter int NUM_VALS = 8,
  parameter int SIZE     = 16,
  parameter int IDX_W    = 3,
  parameter int ODD      = 1,
  parameter int SIGNED   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      advance,
  input  logic                      up_valid,
  input  logic [NUM_VALS*SIZE-1:0]  up_data,
  input  logic [NUM_VALS*IDX_W-1:0] up_idx,
  input  logic                      up_descend,
  output logic                      valid,
  output logic [NUM_VALS*SIZE-1:0]  data,
  output logic [NUM_VALS*IDX_W-1:0] idx,
  output logic                      descend
);

  // Odd layers pair (0,1),(2,3)..; even layers pair (1,2),(3,4)..
  localparam int FIRST = (ODD != 0) ? 0 : 1;

  logic [NUM_VALS*SIZE-1:0]  nxt_data;
  logic [NUM_VALS*IDX_W-1:0] nxt_idx;

  function automatic logic [KEY_MAX_W-1:0] widen(
    input logic [SIZE-1:0] v
  );
    logic signed [SIZE-1:0] sv;
    sv = v;
    if (SIGNED != 0) return KEY_MAX_W'(sv);
    return KEY_MAX_W'(v);
  endfunction

  always_comb begin
    nxt_data = up_data;
    nxt_idx  = up_idx;
    for (int i = FIRST; i + 1 < NUM_VALS; i += 2) begin
      if (cmp_swap(widen(up_data[i*SIZE +: SIZE]),
                   widen(up_data[(i+1)*SIZE +: SIZE]),
                   up_descend, SIGNED != 0)) begin
        nxt_data[i*SIZE +: SIZE]      = up_data[(i+1)*SIZE +: SIZE];
        nxt_data[(i+1)*SIZE +: SIZE]  = up_data[i*SIZE +: SIZE];
        nxt_idx[i*IDX_W +: IDX_W]     = up_idx[(i+1)*IDX_W +: IDX_W];
        nxt_idx[(i+1)*IDX_W +: IDX_W] = up_idx[i*IDX_W +: IDX_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (advance) begin
      valid <= up_valid;
    end
  end

  // Cleared on reset so the final stage presents zeros at the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      idx     <= '0;
      descend <= 1'b0;
    end else if (advance && up_valid) begin
      data    <= nxt_data;
      idx     <= nxt_idx;
      descend <= up_descend;
    end
  end

endmodule

// File: rtl/sort_stream.sv
// Pipelined stable odd-even transposition sorter with index tags.
// in_* valid/ready vector in, out_* sorted vector out, busy = any stage full.
module sort_stream
  import sort_pkg::*;
#(
  parameter int  NUM_VALS = 8,
  parameter int  SIZE     = 16,
  parameter int  SIGNED   = 0,
  localparam int IDX_W    = $clog2(NUM_VALS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_VALS*SIZE-1:0]  in_data,
  input  logic                      in_descend,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_VALS*SIZE-1:0]  out_data,
  output logic [NUM_VALS*IDX_W-1:0] out_idx,
  output logic                      out_descend,
  output logic                      busy
);

  // Index 0 is the input port; index s is the register of stage s.
  logic [NUM_VALS:0]         v;
  logic [NUM_VALS:0]         dsc;
  logic [NUM_VALS*SIZE-1:0]  d [NUM_VALS+1];
  logic [NUM_VALS*IDX_W-1:0] x [NUM_VALS+1];
  logic [NUM_VALS:1]         adv;

  assign v[0]   = in_valid;
  assign dsc[0] = in_descend;
  assign d[0]   = in_data;

  genvar g;
  generate
    for (g = 0; g < NUM_VALS; g++) begin : g_tag
      assign x[0][g*IDX_W +: IDX_W] = IDX_W'(g);
    end
  endgenerate

  // A stage may load when it is empty or its successor moves on.
  // Built as a ripple from the output so empty slots absorb stalls.
  always_comb begin
    logic a;
    a = !v[NUM_VALS] || out_ready;
    adv = '0;
    adv[NUM_VALS] = a;
    for (int s = NUM_VALS - 1; s >= 1; s--) begin
      a      = !v[s] || a;
      adv[s] = a;
    end
  end

  generate
    for (g = 1; g <= NUM_VALS; g++) begin : g_stage
      sort_cas_stage #(
        .NUM_VALS (NUM_VALS),
        .SIZE     (SIZE),
        .IDX_W    (IDX_W),
        .ODD      ((g % 2) == 1 ? 1 : 0),
        .SIGNED   (SIGNED)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .advance    (adv[g]),
        .up_valid   (v[g-1]),
        .up_data    (d[g-1]),
        .up_idx     (x[g-1]),
        .up_descend (dsc[g-1]),
        .valid      (v[g]),
        .data       (d[g]),
        .idx        (x[g]),
        .descend    (dsc[g])
      );
    end
  endgenerate

  assign in_ready    = adv[1];
  assign out_valid   = v[NUM_VALS];
  assign out_data    = d[NUM_VALS];
  assign out_idx     = x[NUM_VALS];
  assign out_descend = dsc[NUM_VALS];
  assign busy        = |v[NUM_VALS:1];

endmodule

// File: tb/tb_sort_stream.sv
// Self-checking bench for sort_stream: rank-based reference model,
// scoreboard compare on every output transfer, plus literal cases.
module tb_sort_stream;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int IW = 3;
  localparam int DW = N * W;
  localparam int XW = N * IW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_descend = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;

  logic          in_ready, out_valid, out_descend, busy;
  logic [DW-1:0] out_data;
  logic [XW-1:0] out_idx;
  logic          in_ready_s, out_valid_s, out_descend_s, busy_s;
  logic [DW-1:0] out_data_s;
  logic [XW-1:0] out_idx_s;

  sort_stream #(.NUM_VALS(N), .SIZE(W), .SIGNED(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_descend(in_descend),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .out_descend(out_descend), .busy(busy)
  );

  sort_stream #(.NUM_VALS(N), .SIZE(W), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_descend(in_descend),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_idx(out_idx_s),
    .out_descend(out_descend_s), .busy(busy_s)
  );

  typedef struct {
    logic [DW-1:0] d0;
    logic [XW-1:0] x0;
    logic [DW-1:0] d1;
    logic [XW-1:0] x1;
    logic          ds;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;

  task automatic check(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic bit less(input logic [W-1:0] a,
                              input logic [W-1:0] b, input bit sgn);
    if (sgn) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  // Final slot of key i = number of keys that rank ahead of it;
  // equal keys rank by original index.
  task automatic model(input logic [DW-1:0] d, input logic ds,
                       input bit sgn, output logic [DW-1:0] od,
                       output logic [XW-1:0] ox);
    od = '0;
    ox = '0;
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] ki;
      int r;
      ki = d[i*W +: W];
      r = 0;
      for (int j = 0; j < N; j++) begin
        logic [W-1:0] kj;
        kj = d[j*W +: W];
        if (ds ? less(ki, kj, sgn) : less(kj, ki, sgn)) r++;
        else if (kj == ki && j < i) r++;
      end
      od[r*W +: W]   = ki;
      ox[r*IW +: IW] = IW'(i);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
        model(in_data, in_descend, 1'b0, e.d0, e.x0);
        model(in_data, in_descend, 1'b1, e.d1, e.x1);
        e.ds = in_descend;
        sb.push_back(e);
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow: got output %h expected none",
                   out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_data_u", out_data, e.d0);
          check("sb_idx_u", out_idx, e.x0);
          check("sb_desc_u", out_descend, e.ds);
          check("sb_valid_s", out_valid_s, 1'b1);
          check("sb_data_s", out_data_s, e.d1);
          check("sb_idx_s", out_idx_s, e.x1);
          check("sb_desc_s", out_descend_s, e.ds);
        end
        n_out++;
      end
    end
  end

  function automatic logic [DW-1:0] rvec();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 2))
        0: r[i*W +: W] = W'($urandom_range(0, 65535));
        1: r[i*W +: W] = W'($urandom_range(0, 3));
        default: r[i*W +: W] = W'(16'h7ffe + W'($urandom_range(0, 3)));
      endcase
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pack_k(input int v[N]);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = v[i][W-1:0];
    return r;
  endfunction

  function automatic logic [XW-1:0] pack_i(input int v[N]);
    logic [XW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = v[i][IW-1:0];
    return r;
  endfunction

  task automatic wait_idle(input string nm);
    for (int t = 0; t < 300 && (busy || busy_s); t++) begin
      @(posedge clk);
      #1;
    end
    check(nm, busy, 1'b0);
  endtask

  // Returns right after the edge that accepted the vector.
  task automatic send_one(input logic [DW-1:0] d, input logic ds);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data = d;
    in_descend = ds;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accepted", ok, 1'b1);
  endtask

  task automatic lit_case(input string nm, input int k[N],
                          input logic ds,
                          input int e0[N], input int i0[N],
                          input int e1[N], input int i1[N]);
    logic [DW-1:0] md;
    logic [XW-1:0] mx;
    model(pack_k(k), ds, 1'b0, md, mx);
    check({nm, "_model_u"}, md, pack_k(e0));
    check({nm, "_model_ui"}, mx, pack_i(i0));
    model(pack_k(k), ds, 1'b1, md, mx);
    check({nm, "_model_s"}, md, pack_k(e1));
    check({nm, "_model_si"}, mx, pack_i(i1));
    out_ready = 1'b1;
    send_one(pack_k(k), ds);
    repeat (6) @(posedge clk);
    #1;
    check({nm, "_early"}, out_valid, 1'b0);
    @(posedge clk);
    #1;
    check({nm, "_valid"}, out_valid, 1'b1);
    check({nm, "_data_u"}, out_data, pack_k(e0));
    check({nm, "_idx_u"}, out_idx, pack_i(i0));
    check({nm, "_data_s"}, out_data_s, pack_k(e1));
    check({nm, "_idx_s"}, out_idx_s, pack_i(i1));
    check({nm, "_desc"}, out_descend, ds);
    wait_idle({nm, "_idle"});
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k[N], e0[N], i0[N], e1[N], i1[N];
    int n0, n1, n_acc;
    logic [DW-1:0] snap;
    logic [XW-1:0] snapx;
    logic acc;

    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, '0);
    check("rst_out_idx", out_idx, '0);
    check("rst_out_desc", out_descend, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    k  = '{7, 3, 9, 1, 5, 8, 2, 6};
    e0 = '{1, 2, 3, 5, 6, 7, 8, 9};
    i0 = '{3, 6, 1, 4, 7, 0, 5, 2};
    lit_case("asc", k, 1'b0, e0, i0, e0, i0);

    e0 = '{9, 8, 7, 6, 5, 3, 2, 1};
    i0 = '{2, 5, 0, 7, 4, 1, 6, 3};
    lit_case("desc", k, 1'b1, e0, i0, e0, i0);

    k  = '{4, 4, 1, 4, 1, 4, 1, 1};
    e0 = '{1, 1, 1, 1, 4, 4, 4, 4};
    i0 = '{2, 4, 6, 7, 0, 1, 3, 5};
    lit_case("ties", k, 1'b0, e0, i0, e0, i0);

    k  = '{1, 65535, 0, 2, 3, 4, 5, 6};
    e0 = '{0, 1, 2, 3, 4, 5, 6, 65535};
    i0 = '{2, 0, 3, 4, 5, 6, 7, 1};
    e1 = '{65535, 0, 1, 2, 3, 4, 5, 6};
    i1 = '{1, 2, 0, 3, 4, 5, 6, 7};
    lit_case("sign", k, 1'b0, e0, i0, e1, i1);

    // Back-to-back stream: one output per cycle starting at cycle 8.
    n0 = n_out;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data = rvec();
      in_descend = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("stream_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      if (c == 6) check("stream_first_early", out_valid, 1'b0);
      if (c >= 7) check("stream_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      check("stream_tail_valid", out_valid, 1'b1);
    end
    @(negedge clk);
    #1;
    check("stream_count", 32'(n_out - n0), 32'd20);
    wait_idle("stream_idle");

    // Stalled consumer: pipeline fills to exactly N vectors.
    n0 = n_out;
    n1 = n_in;
    n_acc = 0;
    out_ready = 1'b0;
    in_data = rvec();
    in_descend = 1'($urandom_range(0, 1));
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (acc) n_acc++;
      @(posedge clk);
      #1;
      if (acc) begin
        in_data = rvec();
        in_descend = 1'($urandom_range(0, 1));
      end
    end
    check("stall_accepts", 32'(n_acc), 32'd8);
    check("stall_in_cnt", 32'(n_in - n1), 32'd8);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    snap = out_data;
    snapx = out_idx;
    repeat (3) @(posedge clk);
    #1;
    check("stall_data_hold", out_data, snap);
    check("stall_idx_hold", out_idx, snapx);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle("stall_idle");
    check("stall_drain", 32'(n_out - n0), 32'd8);

    // Random valid/ready traffic with bubbles and stalls.
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = rvec();
        in_descend = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle("rand_idle");
    check("rand_balance", 32'(n_in), 32'(n_out));

    // Reset with vectors in flight.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data = rvec();
      in_descend = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_busy_s", busy_s, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_data", out_data, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = n_out;
    send_one(rvec(), 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_desc", out_descend, 1'b1);
    wait_idle("post_rst_idle");
    check("post_rst_count", 32'(n_out - n0), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sort_stream.md
# sort_stream

Pipelined, stable odd-even transposition sorter for streaming vectors of NUM_VALS keys, each sorted key carrying its original input index as a tag. Sort direction is selectable per vector and signed or unsigned comparison is chosen by parameter. The pipeline has valid/ready backpressure with bubble collapsing, so a vector retires every cycle when the consumer is ready. It sits between vector producers (score or priority engines) and consumers that need ranked keys and their source positions.

## Interface
Parameters:
- NUM_VALS, default 8: keys per vector; range 2..32.
- SIZE, default 16: key width in bits; range 1..64.
- SIGNED, default 0: 1 selects two's-complement comparison, 0 selects unsigned.
- IDX_W, derived, equal to $clog2(NUM_VALS): tag width.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: reset, asynchronous and active-high.
- in_valid, in, 1: input vector valid.
- in_ready, out, 1: stage 1 can accept.
- in_data, in, NUM_VALS*SIZE: keys; key i occupies [i*SIZE +: SIZE].
- in_descend, in, 1: 0 sorts ascending, 1 sorts descending; sampled with the vector.
- out_valid, out, 1: sorted vector valid.
- out_ready, in, 1: consumer accepts.
- out_data, out, NUM_VALS*SIZE: sorted keys; slot 0 holds the first-ranked key.
- out_idx, out, NUM_VALS*IDX_W: original index of the key in each slot.
- out_descend, out, 1: direction echoed with the vector.
- busy, out, 1: OR of all stage valids.

## Operation
- There are NUM_VALS stages. Stage s (1-based) compare-swaps pairs (0,1),(2,3)… when s is odd, and pairs (1,2),(3,4)… when s is even. The result is registered together with tags, direction and a valid bit.
- Swap rule: swap the pair when key[i] > key[i+1] (ascending) or key[i] < key[i+1] (descending). Comparison uses SIGNED semantics. Equal keys never swap, so the sort is stable and ties keep ascending original index.
- Tag initialisation at input: idx[i] = i. Tags move with their keys on every swap.
- Stage advance: advance[s] = !valid[s] || advance[s+1]. For the last stage, advance = !out_valid || out_ready. in_ready = advance[1].
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- A stage whose advance is low holds its data. A stage that advances with no upstream valid becomes empty (valid = 0).
- Data registers update only when the stage advances with a valid upstream vector. Data registers need not reset.

## Timing
- Latency: NUM_VALS cycles from input transfer to out_valid when out_ready is held high.
- Throughput: 1 vector per cycle. Occupancy is at most NUM_VALS vectors.
- in_ready is combinational from out_ready through the advance chain. There is no combinational path from in_valid or in_data to any output.
- out_* are registered and held stable while out_valid && !out_ready.
- Reset values: all stage valids = 0, out_valid = 0, busy = 0, in_ready = 1, out_data/out_idx/out_descend = 0.
- Reset asserted mid-operation discards all in-flight vectors immediately (asynchronous). The first accept is possible in the first cycle after deassertion.
- Simultaneous input and output transfers on a full pipeline are legal. No vector is lost or duplicated.
- A bubble inserted at any stage collapses when downstream stages stall.

## Structure
- sort_pkg holds the direction enum (SORT_ASC = 0, SORT_DESC = 1) and a function cmp_swap(a, b, descend, signed_mode) returning the swap decision.
- Sub-module sort_cas_stage (parameters NUM_VALS, SIZE, IDX_W, ODD) implements one compare-swap layer plus registers and advance logic. The top level instantiates NUM_VALS copies via generate and computes the advance chain.

## Test plan
- NUM_VALS=8, SIZE=16, ascending, in {7,3,9,1,5,8,2,6}: 8 cycles later out {1,2,3,5,6,7,8,9}, idx {3,6,1,4,7,0,5,2}.
- Same keys with in_descend=1: out {9,8,7,6,5,3,2,1}, idx {2,5,0,7,4,1,6,3}, out_descend=1.
- Ties, ascending, in {4,4,1,4,…,1}: equal keys emerge with strictly ascending idx. SIGNED=1 with {-1(0xFFFF),0,1}: order -1,0,1. SIGNED=0 with the same keys: 0,1,0xFFFF.
- Stream 20 random vectors back to back with out_ready=1: 20 outputs in order, one per cycle, first output at cycle 8.
- Hold out_ready=0 for 12 cycles while driving continuously: exactly 8 vectors are accepted, then in_ready=0 and out_data is stable. Release out_ready: all vectors drain in order with no loss.
- Assert rst with 5 vectors in flight: out_valid=0 and busy=0 immediately. After deassertion, a new vector returns after 8 cycles, with no stale data.
